// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared constants and helpers for lockstep/shadow monitors
package lockstep_pkg;
  localparam int DELAY_MAX = 16;
  localparam int WARM_W = $clog2(DELAY_MAX + 1);
  function automatic logic [31:0] cnt_sat(input logic [31:0] c, input int w);
    logic [31:0] max;
    max = 32'hFFFF_FFFF >> (32 - w);
    return (c == max) ? c : c + 32'd1;
  endfunction
endpackage

// File: rtl/lockstep_delay_line.sv
// lockstep_delay_line: N-stage free-running shift register, cleared by rst
module lockstep_delay_line #(
  parameter int W = 33,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] sr [N];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end
  assign dout = sr[N-1];
endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: delayed-reference vs DUT stream compare with mismatch statistics
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DELAY = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             ref_valid,
  input  logic [WIDTH-1:0] ref_data,
  input  logic             dut_valid,
  input  logic [WIDTH-1:0] dut_data,
  input  logic [WIDTH-1:0] mask,
  output logic             primed,
  output logic             equal,
  output logic             mismatch,
  output logic             error_sticky,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act
);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;
  stage_t din, dly;
  logic [WARM_W-1:0] warm;
  logic mm;
  assign din = '{valid: ref_valid, data: ref_data};
  lockstep_delay_line #(.W(WIDTH + 1), .N(DELAY)) u_dly (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dly)
  );
  assign primed = (warm == WARM_W'(DELAY));
  always_ff @(posedge clk) begin
    if (rst) warm <= '0;
    else if (!primed) warm <= warm + 1'b1;
  end
  always_comb begin
    mm = en & primed & ((dly.valid != dut_valid) |
         (dly.valid & dut_valid & (|((dly.data ^ dut_data) & mask))));
    mismatch = mm;
    equal = ~mm;
  end
  // clear takes effect before a same-cycle mismatch, so that mismatch re-arms capture
  always_ff @(posedge clk) begin
    if (rst) begin
      error_sticky   <= 1'b0;
      mismatch_count <= '0;
      first_exp      <= '0;
      first_act      <= '0;
    end else if (mm) begin
      error_sticky   <= 1'b1;
      mismatch_count <= CNT_W'(cnt_sat(clear ? 32'd0 : 32'(mismatch_count), CNT_W));
      if (clear | ~error_sticky) begin
        first_exp <= dly.data;
        first_act <= dut_data;
      end
    end else if (clear) begin
      error_sticky   <= 1'b0;
      mismatch_count <= '0;
      first_exp      <= '0;
      first_act      <= '0;
    end
  end
endmodule

// File: tb/tb_lockstep_checker.sv
// tb_lockstep_checker: directed vector bench for lockstep_checker (CNT_W=16 and CNT_W=4)
module tb_lockstep_checker;
  logic clk = 0, rst = 1, en = 0, clear = 0, ref_valid = 0, dut_valid = 0;
  logic [31:0] ref_data = 0, dut_data = 0, mask = 32'hFFFF_FFFF;
  logic primed, equal, mismatch, sticky;
  logic [15:0] cnt;
  logic [31:0] fexp, fact;
  logic primed4, equal4, mismatch4, sticky4;
  logic [3:0] cnt4;
  logic [31:0] fexp4, fact4;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  lockstep_checker dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_valid(dut_valid), .dut_data(dut_data), .mask(mask),
    .primed(primed), .equal(equal), .mismatch(mismatch),
    .error_sticky(sticky), .mismatch_count(cnt),
    .first_exp(fexp), .first_act(fact)
  );

  lockstep_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .ref_valid(ref_valid), .ref_data(ref_data),
    .dut_valid(dut_valid), .dut_data(dut_data), .mask(mask),
    .primed(primed4), .equal(equal4), .mismatch(mismatch4),
    .error_sticky(sticky4), .mismatch_count(cnt4),
    .first_exp(fexp4), .first_act(fact4)
  );

  typedef struct {
    logic        en, cl, rv;
    logic [31:0] rd;
    logic        dv;
    logic [31:0] dd, m;
    logic        mm;
    logic [15:0] cnt;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic rv, input logic [31:0] rd,
                       input logic dv, input logic [31:0] dd, input logic [31:0] m);
    en = e; clear = c; ref_valid = rv; ref_data = rd; dut_valid = dv; dut_data = dd; mask = m;
  endtask

  task automatic cyc(input string name, input logic exp_mm);
    #2;
    chk({name, " mismatch"}, mismatch, exp_mm);
    chk({name, " equal"}, equal, !exp_mm);
    chk({name, " mismatch4"}, mismatch4, exp_mm);
    @(posedge clk);
    #1;
  endtask

  task automatic stats(input string name, input logic [15:0] c, input logic [3:0] c4,
                       input logic s, input logic [31:0] fe, input logic [31:0] fa);
    chk({name, " count"}, cnt, c);
    chk({name, " count4"}, cnt4, c4);
    chk({name, " sticky"}, sticky, s);
    chk({name, " sticky4"}, sticky4, s);
    chk({name, " first_exp"}, fexp, fe);
    chk({name, " first_act"}, fact, fa);
    chk({name, " first_exp4"}, fexp4, fe);
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 32'h0000_00AA, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1, 16'd1};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b1, 16'd2};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 16'd2};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 16'd2};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 16'd3};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0055, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd3};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd3};
    tv[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0099, 32'hFFFF_FFFF, 1'b0, 16'd3};
    tv[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0066, 32'h0000_0000, 1'b0, 16'd3};
    tv[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0, 16'd3};

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst primed", primed, 0);
    chk("rst equal", equal, 1);
    stats("rst", 0, 0, 0, 0, 0);
    rst = 0;
    drive(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    chk("warm primed0", primed, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("warm", 0);
      chk($sformatf("warm primed%0d", k + 1), primed, k == 2);
    end
    stats("warm", 0, 0, 0, 0, 0);

    // identical streams, dut lags by DELAY
    for (int i = 0; i < 259; i++) begin
      drive(1, 0, i < 256, 32'(i & 255), i >= 3, 32'((i - 3) & 255), 32'hFFFF_FFFF);
      cyc($sformatf("same%0d", i), 0);
    end
    stats("same", 0, 0, 0, 0, 0);

    // directed vectors
    for (int r = 0; r < 13; r++) begin
      drive(tv[r].en, tv[r].cl, tv[r].rv, tv[r].rd, tv[r].dv, tv[r].dd, tv[r].m);
      cyc($sformatf("vec%0d", r), tv[r].mm);
      chk($sformatf("vec%0d count", r), cnt, tv[r].cnt);
      chk($sformatf("vec%0d count4", r), cnt4, tv[r].cnt[3:0]);
      chk($sformatf("vec%0d sticky", r), sticky, tv[r].cnt != 0);
    end
    stats("vec", 3, 3, 1, 32'h1234_5678, 32'h1234_5679);

    // saturation: 20 valid-skew mismatches
    for (int j = 0; j < 20; j++) begin
      drive(1, 0, j == 17, (j == 17) ? 32'hCAFE_0000 : 32'h0, 1, 0, 32'hFFFF_FFFF);
      cyc($sformatf("sat%0d", j), 1);
    end
    stats("sat", 23, 15, 1, 32'h1234_5678, 32'h1234_5679);

    // clear together with a mismatch
    drive(1, 1, 0, 0, 1, 32'hCAFE_0001, 32'hFFFF_FFFF);
    cyc("clrmm", 1);
    clear = 0;
    stats("clrmm", 1, 1, 1, 32'hCAFE_0000, 32'hCAFE_0001);

    // reset mid-stream
    drive(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mrst primed", primed, 0);
    chk("mrst primed4", primed4, 0);
    chk("mrst equal", equal, 1);
    stats("mrst", 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 32'(8'h11 * (k + 1)), 1, 32'hDEAD, 32'hFFFF_FFFF);
      cyc($sformatf("rewarm%0d", k), 0);
      chk($sformatf("rewarm primed%0d", k), primed, k == 2);
    end
    stats("rewarm", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h11, 32'hFFFF_FFFF);
    cyc("resume0", 0);
    drive(1, 0, 0, 0, 1, 32'h23, 32'hFFFF_FFFF);
    cyc("resume1", 1);
    stats("resume", 1, 1, 1, 32'h22, 32'h23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Parametrised lockstep/shadow checker. Delays a reference stream by DELAY cycles and compares it against a DUT stream, bit-masked and valid-qualified.
- Accumulates mismatch statistics: sticky error, saturating count and first-failure capture.
- Sits beside a duplicated core or pipeline stage as a run-time divergence monitor feeding debug/error CSRs.

Parameters:
- WIDTH, 32, data width compared per cycle.
- DELAY, 3, reference-to-DUT latency in cycles; legal range 1..16.
- CNT_W, 16, width of mismatch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  checking enable; 0 = compare suppressed, delay line still shifts.
- clear  in  1  sync pulse; clears statistics only.
- ref_valid  in  1  reference sample valid.
- ref_data  in  WIDTH  reference sample.
- dut_valid  in  1  DUT sample valid.
- dut_data  in  WIDTH  DUT sample.
- mask  in  WIDTH  1 = bit compared; sampled at DUT side (not delayed).
- primed  out  1  delay line filled since reset.
- equal  out  1  combinational: no mismatch this cycle.
- mismatch  out  1  combinational: mismatch this cycle (= ~equal).
- error_sticky  out  1  set on any mismatch until clear/rst.
- mismatch_count  out  CNT_W  saturating mismatch count.
- first_exp  out  WIDTH  delayed reference data at first mismatch.
- first_act  out  WIDTH  DUT data at first mismatch.

Behaviour:
- Delay line:
  - DELAY stages of {valid, data}, shifting every clk, no stall.
  - Stage DELAY output (d_valid, d_data) is the ref sample from cycle t-DELAY.
- Warm-up counter:
  - Counts 0..DELAY after rst. primed=1 when count==DELAY, then holds.
  - clear does not affect the delay line or primed.
- Compare active when en & primed.
- Mismatch condition (active only):
  - d_valid != dut_valid (valid skew); or
  - d_valid & dut_valid & (((d_data ^ dut_data) & mask) != 0).
- Neither valid, or compare inactive: equal=1, mismatch=0.
- Statistics update on the next clk edge after a mismatch cycle:
  - error_sticky <= 1.
  - mismatch_count += 1, saturating at 2^CNT_W-1; no wrap.
  - If error_sticky was 0: first_exp <= d_data, first_act <= dut_data. Later mismatches do not overwrite.
- clear and mismatch in the same cycle: clear applies first, then the mismatch. Result: count=1, sticky=1, capture refreshed with the current pair.
- rst, including mid-operation:
  - All delay stages valid=0, data=0; warm-up=0; primed=0.
  - error_sticky=0, mismatch_count=0, first_exp=0, first_act=0.
  - equal=1 and mismatch=0 while primed=0.
  - rst has priority over clear.
- mask=0 with both valid never mismatches on data; valid skew is still flagged.
- Latency: ref at cycle t is compared with dut at t+DELAY. Stats are visible at t+DELAY+1.

Decomposition:
- lockstep_pkg: DELAY_MAX=16, a cnt_sat function (saturating increment), and typedef of the {valid, data} stage struct parametrised via WIDTH in the module.
- Sub-module lockstep_delay_line (WIDTH+1 bits, DELAY stages, rst clears). Reused by other shadow monitors.
- Compare, warm-up and statistics logic stays in lockstep_checker.

Test Plan:
- Reset, 3 idle cycles, default params → primed rises at cycle 3. equal=1 throughout; all stats 0.
- Identical streams ref=dut delayed by 3 cycles, values 0x0..0xFF, mask all ones → mismatch never asserted; count=0.
- Inject dut_data=0x1234_5679 vs expected 0x1234_5678 → mismatch pulse same cycle. Next cycle: sticky=1, count=1, first_exp=0x12345678, first_act=0x12345679. A second error 0xAA vs 0xAB → count=2, capture unchanged.
- mask=0xFFFF_FFFE with LSB-only difference → no mismatch. dut_valid=1 while d_valid=0 → mismatch, count increments.
- CNT_W=4, force 20 consecutive mismatches → count saturates at 15. Then clear together with a mismatch → count=1, sticky=1, capture refreshed.
- rst asserted mid-stream with sticky=1 → next cycle all stats 0 and primed=0. A mismatching pair during warm-up is ignored; checking resumes after DELAY cycles.
